vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_scan_gen.sv | 107 ++++++++++
 tb/tb_vga_scan_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA pixel/line scan generator with frame-synchronised lose-screen flag
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lose_req,
  output logic        pix_en,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        visible,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        show_lose,
  output logic [7:0]  frame_cnt
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          pix_en_q, pix_en_d;
  logic          visible_q, visible_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;
  logic          show_lose_q, show_lose_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          div_wrap, h_wrap, v_wrap;

  // Next-state: counters advance on the edge that raises pix_en; decodes use next values so they line up with col/row
  always_comb begin
    div_wrap      = div_cnt_q == D_LAST;
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    pix_en_d      = div_wrap;
    h_wrap        = pix_en_d && h_cnt_q == H_LAST;
    v_wrap        = h_wrap && v_cnt_q == V_LAST;
    h_cnt_d       = !pix_en_d ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d       = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
    frame_start_d = v_wrap;
    show_lose_d   = v_wrap ? lose_req : show_lose_q;
    frame_cnt_d   = v_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    visible_d     = h_cnt_d < H_VIS_L && v_cnt_d < V_VIS_L;
    hsync_d       = (h_cnt_d >= HS_BEG && h_cnt_d < HS_END) ? SYNC_ACT : !SYNC_ACT;
    vsync_d       = (v_cnt_d >= VS_BEG && v_cnt_d < VS_END) ? SYNC_ACT : !SYNC_ACT;
  end

  // State registers; reset forces the scan back to (0,0) with syncs idle and overrides any counting
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_en_q      <= 1'b0;
      visible_q     <= 1'b1;
      hsync_q       <= !SYNC_ACT;
      vsync_q       <= !SYNC_ACT;
      frame_start_q <= 1'b0;
      show_lose_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_en_q      <= pix_en_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      show_lose_q   <= show_lose_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign col         = 32'(h_cnt_q);
  assign row         = 32'(v_cnt_q);
  assign visible     = visible_q;
  assign hsync_n     = hsync_q;
  assign vsync_n     = vsync_q;
  assign frame_start = frame_start_q;
  assign show_lose   = show_lose_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed checks of vga_scan_gen at default, small and tiny timings
module tb_vga_scan_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic d_rst = 1'b1, s_rst = 1'b1, t_rst = 1'b1;
  logic d_lose = 1'b0, s_lose = 1'b0, t_lose = 1'b0;
  logic d_pix, d_vis, d_hs, d_vs, d_fs, d_sl;
  logic s_pix, s_vis, s_hs, s_vs, s_fs, s_sl;
  logic t_pix, t_vis, t_hs, t_vs, t_fs, t_sl;
  logic [31:0] d_col, d_row, s_col, s_row, t_col, t_row;
  logic [7:0] d_fc, s_fc, t_fc;

  vga_scan_gen u_d (
    .clk(clk), .reset(d_rst), .lose_req(d_lose), .pix_en(d_pix), .col(d_col), .row(d_row),
    .visible(d_vis), .hsync_n(d_hs), .vsync_n(d_vs), .frame_start(d_fs), .show_lose(d_sl), .frame_cnt(d_fc)
  );

  vga_scan_gen #(
    .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACT(1'b0)
  ) u_s (
    .clk(clk), .reset(s_rst), .lose_req(s_lose), .pix_en(s_pix), .col(s_col), .row(s_row),
    .visible(s_vis), .hsync_n(s_hs), .vsync_n(s_vs), .frame_start(s_fs), .show_lose(s_sl), .frame_cnt(s_fc)
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACT(1'b1)
  ) u_t (
    .clk(clk), .reset(t_rst), .lose_req(t_lose), .pix_en(t_pix), .col(t_col), .row(t_row),
    .visible(t_vis), .hsync_n(t_hs), .vsync_n(t_vs), .frame_start(t_fs), .show_lose(t_sl), .frame_cnt(t_fc)
  );

  int total = 0, passed = 0;

  typedef struct {
    int k;
    int col;
    int row;
    bit pix;
    bit vis;
    bit hs;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_s_row(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (s_row == r) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic run_s_to_fs(input logic exp_sl, output int bad, output bit seen);
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (s_fs) begin
        seen = 1'b1;
        return;
      end
      if (s_sl !== exp_sl) bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, lowc, first, pc, clks, vlow, bad, fsn, nopix, hbad, vbad, fcbad;
    bit seen, ok;
    tbl[0]  = '{1,    0,   0, 0, 1, 1};
    tbl[1]  = '{2,    1,   0, 1, 1, 1};
    tbl[2]  = '{3,    1,   0, 0, 1, 1};
    tbl[3]  = '{4,    2,   0, 1, 1, 1};
    tbl[4]  = '{1278, 639, 0, 1, 1, 1};
    tbl[5]  = '{1279, 639, 0, 0, 1, 1};
    tbl[6]  = '{1280, 640, 0, 1, 0, 1};
    tbl[7]  = '{1310, 655, 0, 1, 0, 1};
    tbl[8]  = '{1312, 656, 0, 1, 0, 0};
    tbl[9]  = '{1502, 751, 0, 1, 0, 0};
    tbl[10] = '{1504, 752, 0, 1, 0, 1};
    tbl[11] = '{1598, 799, 0, 1, 0, 1};
    tbl[12] = '{1600, 0,   1, 1, 1, 1};
    tbl[13] = '{1602, 1,   1, 1, 1, 1};

    repeat (3) tick();
    chk("reset d col/row", {d_col, d_row}, 64'd0);
    chk("reset d flags", {d_pix, d_vis, d_hs, d_vs, d_fs, d_sl, d_fc}, {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    chk("reset t flags", {t_pix, t_vis, t_hs, t_vs, t_fs, t_sl, t_fc}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

    d_rst = 1'b0;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      while (k < tbl[i].k) begin
        tick();
        k++;
      end
      chk($sformatf("vec k=%0d col/row/pix/vis/hs", tbl[i].k),
          {d_col[15:0], d_row[15:0], d_pix, d_vis, d_hs},
          {16'(tbl[i].col), 16'(tbl[i].row), tbl[i].pix, tbl[i].vis, tbl[i].hs});
    end

    lowc = 0;
    first = -1;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (d_pix && !d_hs) begin
        lowc++;
        if (first < 0) first = int'(d_col);
      end
      if (d_fs || !d_vs) bad++;
    end
    chk("hsync low pix count", 64'(lowc), 64'd96);
    chk("hsync first col", 64'(first), 64'd656);
    chk("line2 col/row", {d_col, d_row}, {32'd1, 32'd2});

    s_rst = 1'b0;
    pc = 0;
    for (int i = 0; i < 10 && !s_pix; i++) tick();
    chk("small first pix col", {s_pix, s_col}, {1'b1, 32'd1});
    pc = 1;
    clks = 0;
    vlow = 0;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      clks++;
      if (s_pix) pc++;
      if (!s_vs) begin
        if (s_pix) vlow++;
        if (s_row != 7 && s_row != 8) bad++;
      end
      if (s_fs) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_start seen", 64'(seen), 64'd1);
    chk("pix per frame", 64'(pc), 64'd165);
    chk("clks first pix to frame_start", 64'(clks), 64'd328);
    chk("frame_start at origin", {s_col, s_row}, 64'd0);
    chk("frame_cnt after frame", 64'(s_fc), 64'd1);
    chk("vsync low pix count", 64'(vlow), 64'd30);
    chk("vsync low off rows 7/8", 64'(bad), 64'd0);
    tick();
    chk("frame_start one clk", 64'(s_fs), 64'd0);

    wait_s_row(3, ok);
    s_lose = 1'b1;
    run_s_to_fs(1'b0, bad, seen);
    chk("lose held off mid-frame", {31'(bad), seen}, {31'd0, 1'b1});
    chk("lose taken at frame_start", 64'(s_sl), 64'd1);
    wait_s_row(5, ok);
    s_lose = 1'b0;
    run_s_to_fs(1'b1, bad, seen);
    chk("lose kept mid-frame", {31'(bad), seen}, {31'd0, 1'b1});
    chk("lose cleared at frame_start", 64'(s_sl), 64'd0);
    wait_s_row(2, ok);
    s_lose = 1'b1;
    wait_s_row(4, ok);
    s_lose = 1'b0;
    run_s_to_fs(1'b0, bad, seen);
    chk("short lose pulse mid-frame", {31'(bad), seen}, {31'd0, 1'b1});
    chk("short lose pulse ignored", 64'(s_sl), 64'd0);
    chk("frame_cnt after 4 frames", 64'(s_fc), 64'd4);

    s_lose = 1'b1;
    run_s_to_fs(1'b0, bad, seen);
    wait_s_row(4, ok);
    for (int i = 0; i < 40 && s_col != 5; i++) tick();
    chk("pre-reset state", {s_sl, s_fc, s_row[7:0], s_col[7:0]}, {1'b1, 8'd5, 8'd4, 8'd5});
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    s_lose = 1'b0;
    chk("mid reset col/row", {s_col, s_row}, 64'd0);
    chk("mid reset flags", {s_pix, s_vis, s_hs, s_vs, s_fs, s_sl, s_fc}, {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    tick();
    chk("post reset clk1", {s_pix, s_col}, {1'b0, 32'd0});
    tick();
    chk("post reset clk2", {s_pix, s_col}, {1'b1, 32'd1});

    t_rst = 1'b0;
    fsn = 0;
    nopix = 0;
    hbad = 0;
    vbad = 0;
    fcbad = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (!t_pix) nopix++;
      if (t_hs !== (t_col >= 5 && t_col <= 6)) hbad++;
      if (t_vs !== (t_row == 4)) vbad++;
      if (t_fs) begin
        fsn++;
        if (t_fc !== 8'(fsn)) fcbad++;
        if (fsn == 256) break;
      end
    end
    chk("tiny frame_start count", 64'(fsn), 64'd256);
    chk("tiny frame_cnt wrapped", 64'(t_fc), 64'd0);
    chk("tiny pix_en every clk", 64'(nopix), 64'd0);
    chk("tiny hsync active-high", 64'(hbad), 64'd0);
    chk("tiny vsync active-high", 64'(vbad), 64'd0);
    chk("tiny frame_cnt sequence", 64'(fcbad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
